// File: rtl/kuz_dec_sched_if.sv
// Handshake bundle between the decryption scheduler, its requesters, the
// response sink and the decoder core.
interface kuz_dec_sched_if;
  logic         key_valid;
  logic [255:0] key;
  logic         key_ready;

  logic         req0_valid;
  logic [127:0] req0_word;
  logic         req0_ready;
  logic         req1_valid;
  logic [127:0] req1_word;
  logic         req1_ready;

  logic         resp_valid;
  logic [127:0] resp_word;
  logic         resp_id;
  logic         resp_err;
  logic         resp_ready;

  logic         core_read_key;
  logic [255:0] core_input_key;
  logic         core_ready;
  logic         core_read_word;
  logic [127:0] core_input_word;
  logic [127:0] core_output_word;
  logic         core_write;

  logic [15:0]  words_done;
  logic         err;

  // Scheduler side
  modport slave (
    input  key_valid, key, req0_valid, req0_word, req1_valid, req1_word,
           resp_ready, core_ready, core_output_word, core_write,
    output key_ready, req0_ready, req1_ready, resp_valid, resp_word,
           resp_id, resp_err, core_read_key, core_input_key,
           core_read_word, core_input_word, words_done, err
  );

  // Environment side (requesters, sink, core)
  modport master (
    output key_valid, key, req0_valid, req0_word, req1_valid, req1_word,
           resp_ready, core_ready, core_output_word, core_write,
    input  key_ready, req0_ready, req1_ready, resp_valid, resp_word,
           resp_id, resp_err, core_read_key, core_input_key,
           core_read_word, core_input_word, words_done, err
  );
endinterface

// File: rtl/kuz_dec_sched.sv
// Kuznyechik decryption scheduler: loads a key into the decoder core, then
// round-robin arbitrates two ciphertext requesters, runs one word at a time
// through the core and returns the plaintext with the requester id.
// Optional watchdog: define KUZ_SCHED_TIMEOUT_EN to bound core waits in
// KEY and WORD by TIMEOUT_CYCLES; otherwise err and resp_err stay 0.
module kuz_dec_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           rst,
  kuz_dec_sched_if.slave bus
);

  typedef enum logic [2:0] {NOKEY, KEY, IDLE, WORD, RESP} state_t;

  state_t       state, state_nxt;
  logic         last_grant, grant, idle_open;
  logic         key_take, fire0, fire1, word_take, timeout;
  logic [255:0] key_q;
  logic [127:0] word_q, resp_word_q;
  logic         resp_id_q, resp_err_q, key_ready_q, err_q;
  logic [15:0]  words_done_q;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("kuz_dec_sched: TIMEOUT_CYCLES must be at least 2");
  end

  assign key_take  = ((state == NOKEY) || (state == IDLE)) && bus.key_valid;
  assign fire0     = bus.req0_valid && bus.req0_ready;
  assign fire1     = bus.req1_valid && bus.req1_ready;
  assign word_take = fire0 || fire1;

`ifdef KUZ_SCHED_TIMEOUT_EN
  logic [31:0] wait_cnt;

  // Watchdog expiry: last allowed cycle of a core wait passed with no answer
  always_comb begin
    timeout = (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) &&
              (((state == KEY) && !bus.core_ready) ||
               ((state == WORD) && !bus.core_write));
  end

  // Wait counter: restarts on every state change, runs while in KEY or WORD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if ((state == KEY) || (state == WORD)) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end
`else
  // No watchdog: core waits are unbounded
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // Round-robin pick: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = bus.req1_valid;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NOKEY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      NOKEY: if (bus.key_valid) state_nxt = KEY;
      KEY: begin
        if (bus.core_ready)  state_nxt = IDLE;
        else if (timeout)    state_nxt = NOKEY;
      end
      IDLE: begin
        if (bus.key_valid)   state_nxt = KEY;
        else if (word_take)  state_nxt = WORD;
      end
      WORD: if (bus.core_write || timeout) state_nxt = RESP;
      RESP: if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = NOKEY;
    endcase
  end

  // State-decoded handshake outputs; a pending key blocks word grants
  always_comb begin
    idle_open          = (state == IDLE) && !bus.key_valid;
    bus.req0_ready     = idle_open && !grant;
    bus.req1_ready     = idle_open && grant;
    bus.core_read_key  = (state == KEY);
    bus.core_read_word = (state == WORD);
    bus.resp_valid     = (state == RESP);
  end

  // Key, word and response registers plus completion/error bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_ready_q  <= 1'b0;
      key_q        <= '0;
      word_q       <= '0;
      resp_word_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      last_grant   <= 1'b1;
      err_q        <= 1'b0;
      words_done_q <= '0;
    end else begin
      key_ready_q <= key_take;
      if (key_take) begin
        key_q <= bus.key;
      end
      if (word_take) begin
        word_q     <= fire1 ? bus.req1_word : bus.req0_word;
        resp_id_q  <= fire1;
        last_grant <= fire1;
      end
      if (state == WORD) begin
        if (bus.core_write) begin
          resp_word_q <= bus.core_output_word;
          resp_err_q  <= 1'b0;
        end else if (timeout) begin
          resp_word_q <= '0;
          resp_err_q  <= 1'b1;
        end
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
      if ((state == RESP) && bus.resp_ready) begin
        words_done_q <= words_done_q + 16'd1;
      end
    end
  end

  assign bus.key_ready       = key_ready_q;
  assign bus.core_input_key  = key_q;
  assign bus.core_input_word = word_q;
  assign bus.resp_word       = resp_word_q;
  assign bus.resp_id         = resp_id_q;
  assign bus.resp_err        = resp_err_q;
  assign bus.words_done      = words_done_q;
  assign bus.err             = err_q;

endmodule

// File: tb/tb_kuz_dec_sched.sv
// Scoreboard bench for kuz_dec_sched: randomized requesters, a stub decoder
// core with random latency, a random-backpressure sink and a response monitor.
module tb_kuz_dec_sched;

  localparam logic [255:0] KAT_KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] KAT_IN  = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam logic [127:0] KAT_OUT = 128'h1122334455667700ffeeddccbbaa9988;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  kuz_dec_sched_if bus();
  kuz_dec_sched #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic         id;
    logic         err;
    logic [127:0] word;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] q0[$];
  logic [127:0] q1[$];
  logic         grants[$];
  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  int unsigned  exp_done = 0;
  int unsigned  word_reads = 0;
  logic         m_last = 1'b1;
  logic [255:0] offered_key = '0;
  logic [255:0] model_key = '0;
  logic [255:0] core_key = '0;
  bit           core_mute = 0;
  bit           hold_valid = 0;
  bit           bp_hold = 0;
  bit           expect_timeout = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in for the real decoder: fixed known answer, otherwise a keyed swap
  function automatic logic [127:0] ref_dec(input logic [127:0] w, input logic [255:0] k);
    if (w == KAT_IN && k == KAT_KEY) return KAT_OUT;
    return {w[63:0], w[127:64]} ^ k[127:0] ^ k[255:128];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Decoder core stub: answers each read request after 0..3 cycles
  initial begin : core_model
    int kcnt;
    int wcnt;
    kcnt = -1;
    wcnt = -1;
    bus.core_ready = 1'b0;
    bus.core_write = 1'b0;
    bus.core_output_word = '0;
    forever begin
      @(posedge clk); #1;
      bus.core_ready = 1'b0;
      bus.core_write = 1'b0;
      if (core_mute || rst) begin
        kcnt = -1;
        wcnt = -1;
      end else begin
        if (bus.core_read_key) begin
          if (kcnt < 0) kcnt = int'($urandom_range(0, 3));
          if (kcnt == 0) begin
            bus.core_ready = 1'b1;
            core_key = bus.core_input_key;
            kcnt = -1;
          end else kcnt--;
        end else kcnt = -1;
        if (bus.core_read_word) begin
          if (wcnt < 0) wcnt = int'($urandom_range(0, 3));
          if (wcnt == 0) begin
            bus.core_write = 1'b1;
            bus.core_output_word = ref_dec(bus.core_input_word, core_key);
            wcnt = -1;
          end else wcnt--;
        end else wcnt = -1;
      end
    end
  end

  // Response sink with random backpressure
  initial begin : sink
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.resp_ready = !bp_hold && ($urandom_range(0, 3) != 0);
    end
  end

  // Requesters: offer queued words, optionally with random idle gaps
  initial begin : requesters
    bit f0, f1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_word  = '0;
    bus.req1_word  = '0;
    forever begin
      @(negedge clk);
      f0 = !rst && bus.req0_valid && bus.req0_ready;
      f1 = !rst && bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (rst) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end else begin
        if (f0) begin
          if (q0.size() != 0) void'(q0.pop_front());
          bus.req0_valid = 1'b0;
        end
        if (f1) begin
          if (q1.size() != 0) void'(q1.pop_front());
          bus.req1_valid = 1'b0;
        end
        if (!bus.req0_valid && q0.size() != 0 && (hold_valid || $urandom_range(0, 2) != 0)) begin
          bus.req0_valid = 1'b1;
          bus.req0_word  = q0[0];
        end
        if (!bus.req1_valid && q1.size() != 0 && (hold_valid || $urandom_range(0, 2) != 0)) begin
          bus.req1_valid = 1'b1;
          bus.req1_word  = q1[0];
        end
      end
    end
  end

  // Issue side: predict the grant and push the expected response
  initial begin : issue_mon
    logic id, pred;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.key_ready) model_key = offered_key;
        if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
          id   = bus.req1_valid && bus.req1_ready;
          pred = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
          check("grant", id, pred);
          check("one_ready", bus.req0_ready && bus.req1_ready, 0);
          m_last = id;
          grants.push_back(id);
          e.id = id;
          if (expect_timeout) begin
            e.err  = 1'b1;
            e.word = '0;
          end else begin
            e.err  = 1'b0;
            e.word = ref_dec(id ? bus.req1_word : bus.req0_word, model_key);
          end
          sb.push_back(e);
        end
      end
    end
  end

  // Response side: pop and compare on every completed response handshake
  initial begin : resp_mon
    exp_t e;
    logic prev_rw;
    prev_rw = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.core_read_word && !prev_rw) word_reads++;
      prev_rw = bus.core_read_word;
      if (!rst && bus.resp_valid && bus.resp_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got word %0h id %0d with no pending request", bus.resp_word, bus.resp_id);
        end else begin
          e = sb.pop_front();
          check("resp_word", bus.resp_word, e.word);
          check("resp_id", bus.resp_id, e.id);
          check("resp_err", bus.resp_err, e.err);
          check("words_done", bus.words_done, exp_done[15:0]);
          exp_done = (exp_done + 1) & 32'hFFFF;
        end
      end
    end
  end

  task automatic drain(input string name, input int unsigned bound);
    int unsigned n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, n < bound, 1);
    @(negedge clk);
  endtask

  task automatic load_key(input logic [255:0] k);
    int unsigned n = 0;
    @(posedge clk); #1;
    bus.key = k;
    bus.key_valid = 1'b1;
    offered_key = k;
    @(negedge clk);
    check("key_blocks_req", {bus.req0_ready, bus.req1_ready}, 0);
    while (!bus.key_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("key_ready_seen", bus.key_ready, 1);
    check("core_read_key_on", bus.core_read_key, 1);
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    @(negedge clk);
    check("key_ready_pulse", bus.key_ready, 0);
    n = 0;
    while (bus.core_read_key && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("key_load_done", bus.core_read_key, 0);
    check("key_in_core", core_key, k);
  endtask

  task automatic wait_read_word(input string name);
    int unsigned n = 0;
    while (!bus.core_read_word && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_read_word"}, bus.core_read_word, 1);
  endtask

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned  n, base, reads0;
    logic [127:0] held;
    bit           ok;
    bus.key_valid = 1'b0;
    bus.key = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_word", bus.resp_word, 0);
    check("rst_resp_id", bus.resp_id, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_words_done", bus.words_done, 0);
    check("rst_err", bus.err, 0);
    check("rst_read_key", bus.core_read_key, 0);
    check("rst_read_word", bus.core_read_word, 0);
    check("rst_input_key", bus.core_input_key, 0);
    check("rst_input_word", bus.core_input_word, 0);
    check("rst_key_ready", bus.key_ready, 0);
    check("rst_req_ready", {bus.req0_ready, bus.req1_ready}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // No key yet: words must wait
    hold_valid = 1;
    @(negedge clk);
    q0.push_back(rand128());
    q1.push_back(rand128());
    ok = 1;
    repeat (8) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) ok = 0;
    end
    check("nokey_blocks_req", ok, 1);

    // Key load, then both requesters held valid: grants alternate from req0
    load_key(KAT_KEY);
    @(negedge clk);
    q0.push_back(rand128());
    q1.push_back(rand128());
    drain("fair", 500);
    check("fair_count", grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) check("fair_grant", grants[i], i % 2);
    end
    check("fair_done", bus.words_done, 4);

    // Known answer through req0 alone
    base = bus.words_done;
    @(negedge clk);
    q0.push_back(KAT_IN);
    drain("kat", 200);
    check("kat_done", bus.words_done - base, 1);

    // Random traffic with a key change part-way
    hold_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) != 0) q0.push_back(rand128());
      else q1.push_back(rand128());
    end
    repeat (20) @(negedge clk);
    load_key({rand128(), rand128()});
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) != 0) q0.push_back(rand128());
      else q1.push_back(rand128());
    end
    drain("random", 3000);
    check("random_done", bus.words_done, 29);

    // Backpressure: response held, nothing else accepted
    bp_hold = 1;
    hold_valid = 1;
    @(negedge clk);
    q0.push_back(rand128());
    q1.push_back(rand128());
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_resp_valid", bus.resp_valid, 1);
    held = bus.resp_word;
    reads0 = word_reads;
    ok = 1;
    repeat (50) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.resp_word !== held || bus.req0_ready || bus.req1_ready) ok = 0;
    end
    check("bp_stable", ok, 1);
    check("bp_no_second_read", word_reads, reads0);
    bp_hold = 0;
    drain("bp", 500);

    // Core never answers a word
    core_mute = 1;
`ifdef KUZ_SCHED_TIMEOUT_EN
    expect_timeout = 1;
    @(negedge clk);
    q0.push_back(rand128());
    wait_read_word("tmo");
    expect_timeout = 0;
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      if (bus.core_read_word) n++;
      @(negedge clk);
    end
    check("tmo_cycles", n, 16);
    check("tmo_err", bus.err, 1);
    drain("tmo", 200);
    core_mute = 0;
    @(negedge clk);
    q1.push_back(rand128());
    drain("after_tmo", 200);
    check("err_sticky", bus.err, 1);
    core_mute = 1;
    @(negedge clk);
    q0.push_back(rand128());
    wait_read_word("stall");
`else
    @(negedge clk);
    q0.push_back(rand128());
    wait_read_word("stall");
    repeat (1000) @(negedge clk);
    check("stall_read_word", bus.core_read_word, 1);
    check("stall_resp_valid", bus.resp_valid, 0);
    check("stall_err", bus.err, 0);
`endif

    // Reset in the middle of WORD
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_async_read_word", bus.core_read_word, 0);
    check("rst_async_input_word", bus.core_input_word, 0);
    sb.delete();
    q0.delete();
    q1.delete();
    grants.delete();
    m_last = 1'b1;
    exp_done = 0;
    core_mute = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    q0.push_back(rand128());
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (bus.req0_ready) ok = 0;
    end
    check("rst_needs_key", ok, 1);
    check("rst_words_cleared", bus.words_done, 0);
    check("rst_err_cleared", bus.err, 0);
    load_key({rand128(), rand128()});
    drain("post_rst", 200);
    check("post_rst_done", bus.words_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kuz_dec_sched.md
KUZ_DEC_SCHED -- requirements
Module: kuz_dec_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: maximum core wait, in cycles, per key load or word when the watchdog is compiled in.
REQ-002 The module SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 key_valid  in  1; key  in  256  new 256-bit decryption key offer.
REQ-006 key_ready  out  1  one-cycle pulse: key accepted.
REQ-007 req0_valid  in  1; req0_word  in  128; req0_ready  out  1  requester 0 ciphertext handshake.
REQ-008 req1_valid  in  1; req1_word  in  128; req1_ready  out  1  requester 1 ciphertext handshake.
REQ-009 resp_valid  out  1; resp_word  out  128; resp_id  out  1; resp_err  out  1; resp_ready  in  1  plaintext response handshake.
REQ-010 core_read_key  out  1; core_input_key  out  256; core_ready  in  1  key-expansion handshake to the decoder core.
REQ-011 core_read_word  out  1; core_input_word  out  128; core_output_word  in  128; core_write  in  1  word handshake to the decoder core.
REQ-012 words_done  out  16  count of completed responses; err  out  1  sticky timeout flag.

Function
REQ-013 States SHALL be NOKEY, KEY, IDLE, WORD and RESP; the state after reset SHALL be NOKEY.
REQ-014 NOKEY: all req*_ready low; on key_valid, latch key, pulse key_ready, go to KEY.
REQ-015 KEY: core_read_key high, core_input_key = latched key; on core_ready high, go to IDLE with core_read_key low in IDLE.
REQ-016 IDLE: key_valid has priority over words; it latches the key, pulses key_ready and goes to KEY, and all req*_ready stay low that cycle.
REQ-017 IDLE word arbitration SHALL be round-robin: with one valid requester, grant it; with both valid, grant the one not granted last; last_grant resets to 1, so req0 wins first.
REQ-018 reqN_ready SHALL be combinational: (state==IDLE) & !key_valid & grant==N; on valid&ready, latch the word, set resp_id=N and go to WORD.
REQ-019 WORD: core_read_word high, core_input_word = latched word held stable; on core_write, capture core_output_word into resp_word, set resp_err=0 and go to RESP.
REQ-020 RESP: resp_valid high and core_read_word low; resp_word/resp_id/resp_err stable until resp_valid&resp_ready, then increment words_done (wrap 0xFFFF->0) and go to IDLE.
REQ-021 Backpressure: resp_ready low holds RESP indefinitely; no new word is accepted.
REQ-022 Latency: core_read_word rises the cycle after the accept edge, and resp_valid rises the cycle after the core_write edge.
REQ-023 core_write or core_ready outside WORD/KEY SHALL be ignored.
REQ-024 key_valid during KEY, WORD or RESP SHALL be ignored (key_ready low) until IDLE.

Reset
REQ-025 While rst is high, the module SHALL go to NOKEY and clear last_grant to 1, words_done, err, resp_valid, resp_word, resp_id, resp_err, core_read_key, core_read_word, core_input_key, core_input_word and key_ready to 0.
REQ-026 Reset mid-KEY or mid-WORD SHALL drop core signals immediately (asynchronously) and discard the latched key and word; a new key is required.

Configuration
REQ-027 With macro KUZ_SCHED_TIMEOUT_EN defined, a cycle counter SHALL run in KEY and WORD and clear on state entry.
REQ-028 Timeout in KEY (count reaches TIMEOUT_CYCLES-1 with no core_ready) SHALL set err and go to NOKEY.
REQ-029 Timeout in WORD SHALL set err and go to RESP with resp_word=0 and resp_err=1.
REQ-030 Without KUZ_SCHED_TIMEOUT_EN, there is no counter, KEY/WORD wait indefinitely, and err and resp_err are tied 0.

Verification
REQ-031 Key load: key=8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef -> key_ready one pulse, core_read_key high until core_ready, then IDLE.
REQ-032 Known answer: req0 word 7f679d90bebc24305a468d42b9d4edcd -> resp_word 1122334455667700ffeeddccbbaa9988, resp_id 0, words_done 1.
REQ-033 Fairness: req0 and req1 both held valid for 4 words -> grants 0,1,0,1; words_done 4.
REQ-034 Backpressure: resp_ready low for 50 cycles -> resp_valid and resp_word stable, req*_ready low, and no second core_read_word.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=16, core_write never asserted) -> resp_err=1, resp_word=0 after 16 cycles in WORD, err sticky; macro off -> still in WORD after 1000 cycles.
REQ-036 Reset asserted mid-WORD -> core_read_word 0 immediately; req0_ready low until a new key completes.
